// File: rtl/pdm_pkg.sv
// -----------------------------------------------------------------------------
// pdm_pkg
// Shared definitions for the PDM record/playback datapath (playback stage and
// mic deserializer).
//   - pdm_state_e  : FSM state enum (IDLE/FETCH/LOAD/PLAY)
//   - S_*          : the same encodings as plain localparams for logic-typed FSMs
//   - BRAM_READ_LAT: clip BRAM read latency in cycles (data follows mem_en)
//   - DEF_DATA_W / DEF_ADDR_W: default word and address widths
// -----------------------------------------------------------------------------
package pdm_pkg;

  localparam int DEF_DATA_W    = 16;
  localparam int DEF_ADDR_W    = 17;
  localparam int BRAM_READ_LAT = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    LOAD  = 2'd2,
    PLAY  = 2'd3
  } pdm_state_e;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_LOAD  = 2'd2;
  localparam logic [1:0] S_PLAY  = 2'd3;

endpackage

// File: rtl/pdm_playback_if.sv
// -----------------------------------------------------------------------------
// pdm_playback_if
// Clip BRAM read port between the playback stage and the clip memory.
//   mem_en   : read enable, one cycle per word
//   mem_addr : read address, valid while mem_en=1
//   mem_data : read data, valid BRAM_READ_LAT cycles after mem_en
// Modports: master = playback stage, slave = BRAM side.
// -----------------------------------------------------------------------------
interface pdm_playback_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 17
);
  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;

  modport master (output mem_en, output mem_addr, input  mem_data);
  modport slave  (input  mem_en, input  mem_addr, output mem_data);
endinterface

// File: rtl/pdm_bit_tick.sv
// -----------------------------------------------------------------------------
// pdm_bit_tick
// Bit-period divider: tick pulses for one cycle every CLK_DIV cycles while
// clear is low. clear holds the count at zero, so the first tick after clear
// falls exactly CLK_DIV cycles later.
//   clock : system clock
//   reset : asynchronous active-low reset
//   clear : synchronous clear, also suppresses tick
//   tick  : one-cycle pulse on the last cycle of each bit period
// CLK_DIV legal range 2..1023.
// -----------------------------------------------------------------------------
module pdm_bit_tick #(
  parameter int CLK_DIV = 50
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic tick
);
  localparam int            CW   = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] cnt;

  assign tick = !clear && (cnt == LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + ONE;
    end
  end
endmodule

// File: rtl/pdm_playback.sv
// -----------------------------------------------------------------------------
// pdm_playback
// Streams clip words start_addr..end_addr (inclusive, modulo 2^ADDR_W) out of
// the clip BRAM and re-serializes each MSB-first onto a 1-bit PDM stream.
// One word is prefetched while the current one shifts out, so consecutive
// words play back to back with no gap.
//   clock, reset         : system clock, asynchronous active-low reset
//   start                : one-cycle start command, accepted only in IDLE
//   stop                 : level abort; wins over start in IDLE
//   start_addr, end_addr : clip bounds, latched on an accepted start
//   mem (master)         : BRAM read port (mem_en / mem_addr / mem_data)
//   audio_out            : PDM bitstream
//   audio_sd             : amplifier enable, high only while playing
//   busy                 : high from the cycle after start until back in IDLE
//   done                 : one-cycle pulse on normal completion only
// -----------------------------------------------------------------------------
module pdm_playback
  import pdm_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int CLK_DIV = 50
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  pdm_playback_if.master    mem,
  output logic              audio_out,
  output logic              audio_sd,
  output logic              busy,
  output logic              done
);
  localparam int            BW       = $clog2(DATA_W);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);
  localparam logic [BW-1:0] BIT_ONE  = BW'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  logic [1:0]        state;
  logic [ADDR_W-1:0] addr_q;    // address of the most recently issued read
  logic [ADDR_W-1:0] end_q;
  logic [DATA_W-1:0] shift_q;
  logic [DATA_W-1:0] pf_q;
  logic              pf_vld;
  logic              rd_pend;   // a prefetch read was issued last cycle
  logic [BW-1:0]     bit_cnt;
  logic              done_q;

  logic              tick;
  logic              more;
  logic              word_end;
  logic              issue_fetch;
  logic              issue_next;
  logic [ADDR_W-1:0] addr_nxt;

  pdm_bit_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clock (clock),
    .reset (reset),
    .clear (state != S_PLAY),
    .tick  (tick)
  );

  assign addr_nxt = addr_q + ADDR_ONE;
  assign more     = (addr_q != end_q);
  assign word_end = tick && (bit_cnt == LAST_BIT);

  // A prefetch is issued from LOAD, and at each word boundary where the
  // prefetched word is being consumed and another word still lies beyond it.
  assign issue_fetch = (state == S_FETCH);
  assign issue_next  = ((state == S_LOAD) && more) ||
                       ((state == S_PLAY) && word_end && pf_vld && more);

  assign mem.mem_en   = issue_fetch || issue_next;
  assign mem.mem_addr = issue_fetch ? addr_q : (issue_next ? addr_nxt : '0);

  // Outputs decode from async-reset state so reset clears them immediately.
  assign audio_out = (state == S_PLAY) && shift_q[DATA_W-1];
  assign audio_sd  = (state == S_PLAY);
  assign busy      = (state != S_IDLE);
  assign done      = done_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      addr_q  <= '0;
      end_q   <= '0;
      shift_q <= '0;
      pf_q    <= '0;
      pf_vld  <= 1'b0;
      rd_pend <= 1'b0;
      bit_cnt <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      rd_pend <= issue_next;

      // Prefetch capture, one cycle after its read
      if (rd_pend) begin
        pf_q   <= mem.mem_data;
        pf_vld <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (start && !stop) begin
            addr_q <= start_addr;
            end_q  <= end_addr;
            pf_vld <= 1'b0;
            state  <= S_FETCH;
          end
        end
        S_FETCH: begin
          state <= S_LOAD;
        end
        S_LOAD: begin
          shift_q <= mem.mem_data;
          bit_cnt <= '0;
          if (more) addr_q <= addr_nxt;
          state   <= S_PLAY;
        end
        S_PLAY: begin
          if (word_end) begin
            bit_cnt <= '0;
            if (pf_vld) begin
              shift_q <= pf_q;
              pf_vld  <= 1'b0;
              if (more) addr_q <= addr_nxt;
            end else begin
              state  <= S_IDLE;
              done_q <= 1'b1;
            end
          end else if (tick) begin
            shift_q <= shift_q << 1;
            bit_cnt <= bit_cnt + BIT_ONE;
          end
        end
        default: state <= S_IDLE;
      endcase

      // Abort: any read in flight is dropped and done is not raised
      if (stop && (state != S_IDLE)) begin
        state   <= S_IDLE;
        pf_vld  <= 1'b0;
        rd_pend <= 1'b0;
        done_q  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_pdm_playback.sv
// -----------------------------------------------------------------------------
// tb_pdm_playback
// Directed bench for pdm_playback (DATA_W=16, ADDR_W=4, CLK_DIV=4) with a
// one-cycle-latency BRAM model and a read-address log.
// -----------------------------------------------------------------------------
module tb_pdm_playback;
  localparam int DW  = 16;
  localparam int AW  = 4;
  localparam int DIV = 4;

  logic          clock;
  logic          reset;
  logic          start;
  logic          stop;
  logic [AW-1:0] start_addr;
  logic [AW-1:0] end_addr;
  logic          audio_out;
  logic          audio_sd;
  logic          busy;
  logic          done;

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] rom [16];
  logic [AW-1:0] rd_log [$];

  pdm_playback_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  pdm_playback #(.DATA_W(DW), .ADDR_W(AW), .CLK_DIV(DIV)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .stop       (stop),
    .start_addr (start_addr),
    .end_addr   (end_addr),
    .mem        (bus),
    .audio_out  (audio_out),
    .audio_sd   (audio_sd),
    .busy       (busy),
    .done       (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // BRAM model: data one cycle after mem_en; every read address is logged
  always @(posedge clock) begin
    if (bus.mem_en) begin
      bus.mem_data <= rom[bus.mem_addr];
      rd_log.push_back(bus.mem_addr);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_reads(input string tag, input logic [AW-1:0] sa, input int n);
    logic [AW-1:0] a;
    check({tag, "_nreads"}, 32'(rd_log.size()), 32'(n));
    for (int j = 0; j < n && j < rd_log.size(); j++) begin
      a = sa + AW'(j);
      check({tag, "_raddr"}, 32'(rd_log[j]), 32'(a));
    end
  endtask

  // Full clip run from start pulse through done; optionally pulses start with
  // other addresses mid-play, which must be ignored.
  task automatic run_clip(input string tag, input logic [AW-1:0] sa,
                          input logic [AW-1:0] ea, input bit restart);
    int            n;
    logic [AW-1:0] wa;
    logic [DW-1:0] w;
    logic          b;
    n = ((int'(ea) - int'(sa)) & 15) + 1;
    rd_log.delete();
    start_addr = sa;
    end_addr   = ea;
    start      = 1'b1;
    step();
    start      = 1'b0;
    // FETCH
    check({tag, "_fetch"}, 32'({busy, bus.mem_en, audio_sd}), 32'(3'b110));
    check({tag, "_fetch_addr"}, 32'(bus.mem_addr), 32'(sa));
    step();
    // LOAD: prefetch only when more than one word
    check({tag, "_load_en"}, 32'({busy, bus.mem_en, audio_sd}), 32'({1'b1, n > 1, 1'b0}));
    if (n > 1) begin
      wa = sa + AW'(1);
      check({tag, "_load_addr"}, 32'(bus.mem_addr), 32'(wa));
    end
    step();
    for (int k = 0; k < n * DW * DIV; k++) begin
      wa = sa + AW'(k / (DW * DIV));
      w  = rom[wa];
      b  = w[DW - 1 - ((k / DIV) % DW)];
      check({tag, "_play"}, 32'({done, busy, audio_sd, audio_out}), 32'({3'b011, b}));
      if (restart && k == 20) begin
        start      = 1'b1;
        start_addr = 4'd7;
        end_addr   = 4'd9;
      end
      if (restart && k == 21) start = 1'b0;
      step();
    end
    check({tag, "_done"}, 32'({done, busy, audio_sd, audio_out, bus.mem_en}), 32'(5'b10000));
    step();
    check({tag, "_done_once"}, 32'({done, busy}), 32'(2'b00));
    check_reads(tag, sa, n);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rom[i] = 16'(16'h1111 * i);
    rom[0]  = 16'hA5F0;
    rom[1]  = 16'h0F0F;
    rom[3]  = 16'h6C39;
    rom[5]  = 16'h8001;
    rom[8]  = 16'hF00D;
    rom[9]  = 16'h3CA5;
    rom[10] = 16'h5A5A;
    rom[14] = 16'h1234;
    rom[15] = 16'hC3C3;

    reset      = 1'b0;
    start      = 1'b0;
    stop       = 1'b0;
    start_addr = '0;
    end_addr   = '0;
    #12;
    check("reset_outs", 32'({audio_out, audio_sd, busy, done, bus.mem_en}), 32'(0));
    check("reset_addr", 32'(bus.mem_addr), 32'(0));
    #3 reset = 1'b1;
    step();
    check("idle_outs", 32'({audio_out, audio_sd, busy, done, bus.mem_en}), 32'(0));

    // Two-word clip, boundary without gap
    run_clip("t1", 4'd0, 4'd1, 1'b0);
    // Single word, no prefetch
    run_clip("t2", 4'd5, 4'd5, 1'b0);
    // Address wrap 14,15,0,1
    run_clip("t3", 4'd14, 4'd1, 1'b0);

    // Stop mid-word 1 of a 3-word clip
    rd_log.delete();
    start_addr = 4'd8;
    end_addr   = 4'd10;
    start      = 1'b1;
    step();
    start      = 1'b0;
    step();
    step();
    for (int k = 0; k < DW * DIV + 10; k++) step();
    check("t4_playing", 32'({busy, audio_sd}), 32'(2'b11));
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("t4_stopped", 32'({done, busy, audio_sd, audio_out, bus.mem_en}), 32'(0));
    for (int k = 0; k < 5; k++) begin
      step();
      check("t4_no_done", 32'({done, busy, bus.mem_en}), 32'(0));
    end
    check_reads("t4", 4'd8, 3);
    run_clip("t4_replay", 4'd3, 4'd3, 1'b0);

    // Start pulsed while busy is ignored
    run_clip("t5", 4'd0, 4'd1, 1'b1);

    // Asynchronous reset mid-play
    start_addr = 4'd0;
    end_addr   = 4'd1;
    start      = 1'b1;
    step();
    start      = 1'b0;
    step();
    step();
    check("t5_pre_rst", 32'({busy, audio_sd, audio_out}), 32'(3'b111));
    #3 reset = 1'b0;
    #1;
    check("t5_async_rst", 32'({audio_out, audio_sd, busy, done, bus.mem_en}), 32'(0));
    #2 reset = 1'b1;
    step();
    check("t5_post_rst", 32'({busy, bus.mem_en}), 32'(0));

    // start and stop together in IDLE: stop wins
    rd_log.delete();
    start_addr = 4'd2;
    end_addr   = 4'd4;
    start      = 1'b1;
    stop       = 1'b1;
    step();
    start      = 1'b0;
    stop       = 1'b0;
    check("t6_idle", 32'({busy, bus.mem_en}), 32'(0));
    step();
    check("t6_still_idle", 32'({busy, bus.mem_en, done}), 32'(0));
    check("t6_no_reads", 32'(rd_log.size()), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
